// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM states, port ids,
// and the strobe vector layout {UB_N, LB_N, WE_N, CE_N, OE_N}.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // All strobes deasserted (active low)
    localparam logic [4:0] STROBE_IDLE = 5'b11111;

    // Strobe vector for an active access cycle
    function automatic logic [4:0] access_strobes(input logic we, input logic [1:0] be);
        return {~be[1], ~be[0], ~we, 1'b0, we};
    endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Two-way round-robin grant between fetch (I) and memory (D) requesters.
// last_grant resets to I so that D wins the first tie.
module sram_rr_arbiter
    import sram_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_valid,
    output logic grant,
    output logic any_req
);

    port_t last_grant;

    // Combinational winner selection: single requester wins, tie goes opposite last_grant
    always_comb begin
        any_req = i_req | d_req;
        if (i_req && d_req) begin
            grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (d_req) begin
            grant = PORT_D;
        end else begin
            grant = PORT_I;
        end
    end

    // Remember the most recent winner whenever a grant is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT_I;
        end else if (grant_valid && any_req) begin
            last_grant <= port_t'(grant);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one external 16-bit SRAM between the fetch port (I, read only) and
// the memory port (D, read/write). Each access is a fixed IDLE/ACCESS/DONE
// sequence with registered strobes and a one-cycle ack on completion.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_UB_N_O,
    output logic              SRAM_LB_N_O,
    output logic              SRAM_WE_N_O,
    output logic              SRAM_CE_N_O,
    output logic              SRAM_OE_N_O
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    port_t             gnt_port;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [4:0]        strobes;
    logic              dq_oe;
    logic              grant;
    logic              any_req;

    sram_rr_arbiter u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .d_req       (d_req),
        .grant_valid (state == ST_IDLE),
        .grant       (grant),
        .any_req     (any_req)
    );

    assign SRAM_DQ     = dq_oe ? lat_wdata : {DATA_W{1'bz}};
    assign SRAM_UB_N_O = strobes[4];
    assign SRAM_LB_N_O = strobes[3];
    assign SRAM_WE_N_O = strobes[2];
    assign SRAM_CE_N_O = strobes[1];
    assign SRAM_OE_N_O = strobes[0];

    // Access sequencer: strobes for the coming ACCESS phase are loaded at grant so
    // every pin comes straight from a flop; read data is captured at the edge that
    // ends the last ACCESS cycle, the same edge that drops the strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            gnt_port  <= PORT_I;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            strobes   <= STROBE_IDLE;
            dq_oe     <= 1'b0;
            SRAM_ADDR <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_port <= port_t'(grant);
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ACCESS;
                        if (grant == PORT_D) begin
                            lat_we    <= d_we;
                            lat_wdata <= d_wdata;
                            SRAM_ADDR <= d_addr;
                            strobes   <= access_strobes(d_we, d_be);
                            dq_oe     <= d_we;
                        end else begin
                            lat_we    <= 1'b0;
                            SRAM_ADDR <= i_addr;
                            strobes   <= access_strobes(1'b0, 2'b11);
                            dq_oe     <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        state   <= ST_DONE;
                        strobes <= STROBE_IDLE;
                        dq_oe   <= 1'b0;
                        if (gnt_port == PORT_D) begin
                            d_ack <= 1'b1;
                            if (!lat_we) begin
                                d_rdata <= SRAM_DQ;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= SRAM_DQ;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a driver issues request rounds, a
// reference model orders them and predicts data, a monitor checks pins and acks.
module tb_sram_port_arbiter;

    localparam int W = 2;

    typedef struct {
        bit          port_d;
        bit          we;
        logic [1:0]  be;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [17:0] i_addr = '0;
    logic [15:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_be = '0;
    logic [17:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        busy;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    int n_cmp = 0;
    int n_bad = 0;

    acc_t exp_q[$];
    acc_t ireq[$];
    acc_t dreq[$];
    logic [15:0] ref_mem [256];
    logic [15:0] dev_mem [256];
    bit          m_last_d = 1'b0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(18), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .busy(busy), .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
        .SRAM_UB_N_O(ub_n), .SRAM_LB_N_O(lb_n), .SRAM_WE_N_O(we_n),
        .SRAM_CE_N_O(ce_n), .SRAM_OE_N_O(oe_n)
    );

    // Behavioural SRAM device: drives on read, writes enabled lanes each write cycle
    wire dev_drive = !ce_n && !oe_n && we_n;
    assign sram_dq = dev_drive ? dev_mem[sram_addr[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) dev_mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
            if (!ub_n) dev_mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks pins at access start/during access and pops the scoreboard on ack
    int          ce_cnt = 0;
    bit          prev_ce = 1'b1;
    logic [15:0] exp_last_d = '0;
    always @(negedge clk) begin
        if (rst) begin
            ce_cnt     = 0;
            prev_ce    = 1'b1;
            exp_last_d = '0;
        end else begin
            if (i_ack && d_ack) check("ack_overlap", 32'd1, 32'd0);
            if (!ce_n) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", 32'd1, 32'd0);
                end else begin
                    if (prev_ce) check("addr", 32'(sram_addr), 32'(exp_q[0].addr));
                    check("we_n", 32'(we_n), 32'(!exp_q[0].we));
                    check("oe_n", 32'(oe_n), 32'(exp_q[0].we));
                    check("ub_n", 32'(ub_n), 32'(!exp_q[0].be[1]));
                    check("lb_n", 32'(lb_n), 32'(!exp_q[0].be[0]));
                end
                ce_cnt++;
            end
            if (i_ack || d_ack) begin
                check("done_strobes", 32'({ub_n, lb_n, we_n, ce_n, oe_n}), 32'h1f);
                check("strobe_width", 32'(ce_cnt), 32'(W));
                check("busy_done", 32'(busy), 32'd1);
                ce_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    check("ack_port", 32'(d_ack), 32'(e.port_d));
                    if (!e.port_d) begin
                        check("i_rdata", 32'(i_rdata), 32'(e.rdata));
                    end else if (!e.we) begin
                        check("d_rdata", 32'(d_rdata), 32'(e.rdata));
                        exp_last_d = e.rdata;
                    end else begin
                        check("d_rdata_hold", 32'(d_rdata), 32'(exp_last_d));
                    end
                end
            end
            prev_ce = ce_n;
        end
    end

    task automatic add_i(input logic [17:0] addr);
        acc_t a;
        a = '{port_d: 1'b0, we: 1'b0, be: 2'b11, addr: addr, wdata: '0, rdata: '0};
        ireq.push_back(a);
    endtask

    task automatic add_d(input bit we, input logic [1:0] be, input logic [17:0] addr,
                         input logic [15:0] wdata);
        acc_t a;
        a = '{port_d: 1'b1, we: we, be: be, addr: addr, wdata: wdata, rdata: '0};
        dreq.push_back(a);
    endtask

    // Reference model: round-robin order, byte-lane writes, full-word reads
    task automatic predict();
        int a = 0;
        int b = 0;
        while (a < ireq.size() || b < dreq.size()) begin
            bit   pick_d;
            acc_t e;
            if (a < ireq.size() && b < dreq.size()) pick_d = !m_last_d;
            else pick_d = (b < dreq.size());
            m_last_d = pick_d;
            if (pick_d) begin e = dreq[b]; b++; end
            else begin e = ireq[a]; a++; end
            if (e.we) begin
                if (e.be[0]) ref_mem[e.addr[7:0]][7:0]  = e.wdata[7:0];
                if (e.be[1]) ref_mem[e.addr[7:0]][15:8] = e.wdata[15:8];
            end else begin
                e.rdata = ref_mem[e.addr[7:0]];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic present_i(input int k);
        if (k < ireq.size()) begin i_req = 1'b1; i_addr = ireq[k].addr; end
        else begin i_req = 1'b0; i_addr = $urandom(); end
    endtask

    task automatic present_d(input int k);
        if (k < dreq.size()) begin
            d_req = 1'b1; d_we = dreq[k].we; d_be = dreq[k].be;
            d_addr = dreq[k].addr; d_wdata = dreq[k].wdata;
        end else begin
            d_req = 1'b0; d_we = $urandom(); d_be = $urandom(); d_addr = $urandom();
        end
    endtask

    // Drive queued requests, each port holding req until all its accesses ack
    task automatic run_round();
        int ni = ireq.size();
        int nd = dreq.size();
        int ki = 0;
        int kd = 0;
        int k  = 0;
        int t  = 0;
        int budget = (ni + nd + 1) * (W + 2) + 10;
        predict();
        @(negedge clk);
        present_i(0);
        present_d(0);
        while ((ki < ni || kd < nd) && t < budget) begin
            @(negedge clk);
            t++;
            if (i_ack || d_ack) begin
                k++;
                check("ack_time", 32'(t), 32'((W + 1) + (k - 1) * (W + 2)));
                if (i_ack) begin ki++; present_i(ki); end
                if (d_ack) begin kd++; present_d(kd); end
            end
        end
        if (t >= budget) begin
            check("round_timeout", 32'(t), 32'(budget - 1));
            exp_q.delete();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        ireq.delete();
        dreq.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'($urandom());
            dev_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk);
        check("rst_strobes", 32'({ub_n, lb_n, we_n, ce_n, oe_n}), 32'h1f);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_acks", 32'({i_ack, d_ack}), 32'd0);
        check("rst_rdata", 32'({i_rdata, d_rdata}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a D write; data equals current contents so the
        // partially completed write leaves memory unchanged
        add_d(1'b1, 2'b11, 18'h00020, ref_mem[8'h20]);
        predict();
        dreq.delete();
        @(negedge clk);
        present_d(0);
        d_we = 1'b1; d_be = 2'b11; d_addr = 18'h00020; d_wdata = ref_mem[8'h20];
        d_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_strobes", 32'({ub_n, lb_n, we_n, ce_n, oe_n}), 32'h1f);
        check("midrst_acks", 32'({i_ack, d_ack}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        d_req = 1'b0;
        exp_q.delete();
        m_last_d = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_strobes", 32'({ub_n, lb_n, we_n, ce_n, oe_n}), 32'h1f);

        // Both requesters from reset: D wins first tie, then alternation
        add_i(18'h00031); add_i(18'h00032);
        add_d(1'b0, 2'b11, 18'h00041, '0); add_d(1'b0, 2'b11, 18'h00042, '0);
        run_round();

        // Single I read of a known word
        ref_mem[8'h10] = 16'h1234; dev_mem[8'h10] = 16'h1234;
        add_i(18'h00010);
        run_round();

        // Lower-byte write then full read-back
        ref_mem[8'h20] = 16'hA55A; dev_mem[8'h20] = 16'hA55A;
        add_d(1'b1, 2'b01, 18'h00020, 16'hBEEF);
        run_round();
        add_d(1'b0, 2'b11, 18'h00020, '0);
        run_round();
        check("byte_merge", 32'(ref_mem[8'h20]), 32'h0000A5EF);

        // D holds req through ack: identical access repeats back to back
        add_d(1'b0, 2'b11, 18'h00010, '0); add_d(1'b0, 2'b11, 18'h00010, '0);
        run_round();

        // No-op byte enables still complete and ack
        add_d(1'b1, 2'b00, 18'h00055, 16'hFFFF);
        run_round();

        // Randomised rounds
        for (int r = 0; r < 40; r++) begin
            int ni = $urandom_range(0, 3);
            int nd = $urandom_range((ni == 0) ? 1 : 0, 3);
            for (int j = 0; j < ni; j++) add_i(18'($urandom()));
            for (int j = 0; j < nd; j++)
                add_d(1'($urandom()), 2'($urandom()), 18'($urandom()), 16'($urandom()));
            run_round();
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
